// File: rtl/blowfish_round_ctrl_if.sv
// Block, P-array write and F-unit signals of the Blowfish round sequencer.
// The slave modport is the sequencer; the master is the surrounding system.
interface blowfish_round_ctrl_if;
    logic        mode;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready;
    logic        p_wr_en;
    logic [4:0]  p_wr_addr;
    logic [31:0] p_wr_data;
    logic        p_wr_err;
    logic [31:0] f_in;
    logic [31:0] f_out;
    logic        busy;

    modport slave (
        input  mode, in_valid, in_data, out_ready,
        input  p_wr_en, p_wr_addr, p_wr_data, f_out,
        output in_ready, out_valid, out_data, p_wr_err, f_in, busy
    );

    modport master (
        output mode, in_valid, in_data, out_ready,
        output p_wr_en, p_wr_addr, p_wr_data, f_out,
        input  in_ready, out_valid, out_data, p_wr_err, f_in, busy
    );
endinterface

// File: rtl/blowfish_round_ctrl.sv
// Blowfish round sequencer: one Feistel round per cycle over an external F unit,
// owns the P-array and keeps one 64-bit block in flight.
//   state | meaning
//   IDLE  | waiting for a block; P-array writable
//   ROUND | one Feistel round per cycle, k counts rounds done
//   FINAL | output whitening with the two outer P entries
//   HOLD  | result presented until the consumer takes it
module blowfish_round_ctrl #(
    parameter int ROUNDS = 16
) (
    input  logic                clock,
    input  logic                reset,
    blowfish_round_ctrl_if.slave bus
);
    localparam int         PDEPTH   = ROUNDS + 2;
    localparam logic [4:0] LAST_IDX = 5'(ROUNDS + 1);
    localparam logic [4:0] LAST_K   = 5'(ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] l_q, l_d;
    logic [31:0] r_q, r_d;
    logic [4:0]  k_q, k_d;
    logic        mode_q, mode_d;
    logic [63:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        p_wr_err_q, p_wr_err_d;

    logic [31:0] p_q [PDEPTH];
    logic [4:0]  p_idx;
    logic [31:0] p_rnd;
    logic [31:0] p_a;
    logic [31:0] p_b;
    logic        p_wr_ok;

    // Decrypt walks the P-array backwards and swaps the whitening pair.
    assign p_idx   = mode_q ? (LAST_IDX - k_q) : k_q;
    assign p_rnd   = p_q[p_idx];
    assign p_a     = mode_q ? p_q[0] : p_q[ROUNDS + 1];
    assign p_b     = mode_q ? p_q[1] : p_q[ROUNDS];
    assign p_wr_ok = (state_q == IDLE) && (bus.p_wr_addr <= LAST_IDX);

    // Key material survives reset, so the array has no reset branch.
    always_ff @(posedge clock) begin
        if (bus.p_wr_en && p_wr_ok) begin
            p_q[bus.p_wr_addr] <= bus.p_wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            l_q         <= '0;
            r_q         <= '0;
            k_q         <= '0;
            mode_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            p_wr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            l_q         <= l_d;
            r_q         <= r_d;
            k_q         <= k_d;
            mode_q      <= mode_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            p_wr_err_q  <= p_wr_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        l_d         = l_q;
        r_d         = r_q;
        k_d         = k_q;
        mode_d      = mode_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        p_wr_err_d  = bus.p_wr_en && !p_wr_ok;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    l_d     = bus.in_data[63:32];
                    r_d     = bus.in_data[31:0];
                    mode_d  = bus.mode;
                    k_d     = '0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                l_d = r_q ^ bus.f_out;
                r_d = l_q ^ p_rnd;
                k_d = k_q + 5'd1;
                if (k_q == LAST_K) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                out_data_d  = {r_q ^ p_a, l_q ^ p_b};
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.p_wr_err  = p_wr_err_q;
    assign bus.f_in      = (state_q == ROUND) ? (l_q ^ p_rnd) : 32'h0;
endmodule

// File: tb/tb_blowfish_round_ctrl.sv
// Bench for blowfish_round_ctrl: directed vector table plus multi-cycle sequences.
// Real Blowfish tables are derived from hex digits of pi computed at time zero.
module tb_blowfish_round_ctrl;
    localparam int BN = 1047;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    blowfish_round_ctrl_if bus ();

    blowfish_round_ctrl #(.ROUNDS(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    bit [31:0] bn_pow [BN];
    bit [31:0] bn_t   [BN];
    bit [31:0] bn_acc [BN];
    bit [31:0] bn_pi  [BN];

    bit [31:0] sbox [4][256];
    bit [31:0] mp  [18];
    bit [31:0] bfp [18];
    bit        f_model_en = 1'b0;
    int        cur_key = -1;

    function automatic logic [31:0] bf_f(input logic [31:0] x);
        return ((sbox[0][x[31:24]] + sbox[1][x[23:16]]) ^ sbox[2][x[15:8]]) + sbox[3][x[7:0]];
    endfunction

    always_comb bus.f_out = f_model_en ? bf_f(bus.f_in) : 32'h0;

    function automatic logic [63:0] bf_crypt(input logic [63:0] blk, input bit dec);
        logic [31:0] l, r, t;
        l = blk[63:32];
        r = blk[31:0];
        for (int i = 0; i < 16; i++) begin
            l = l ^ (dec ? mp[17 - i] : mp[i]);
            r = r ^ bf_f(l);
            t = l; l = r; r = t;
        end
        t = l; l = r; r = t;
        r = r ^ (dec ? mp[1] : mp[16]);
        l = l ^ (dec ? mp[0] : mp[17]);
        return {l, r};
    endfunction

    // Fixed-point bignum helpers: limb 0 is the integer part.
    task automatic div_pow(input bit [63:0] d);
        bit [63:0] rem, cur;
        rem = 0;
        for (int i = 0; i < BN; i++) begin
            cur = (rem << 32) | 64'(bn_pow[i]);
            bn_pow[i] = 32'(cur / d);
            rem = cur % d;
        end
    endtask

    task automatic div_into_t(input bit [63:0] d);
        bit [63:0] rem, cur;
        rem = 0;
        for (int i = 0; i < BN; i++) begin
            cur = (rem << 32) | 64'(bn_pow[i]);
            bn_t[i] = 32'(cur / d);
            rem = cur % d;
        end
    endtask

    task automatic acc_addsub(input bit sub);
        bit [63:0] s, c;
        c = 0;
        for (int i = BN - 1; i >= 0; i--) begin
            if (sub) begin
                s = 64'(bn_acc[i]) - 64'(bn_t[i]) - c;
                c = {63'b0, s[63]};
            end else begin
                s = 64'(bn_acc[i]) + 64'(bn_t[i]) + c;
                c = s >> 32;
            end
            bn_acc[i] = s[31:0];
        end
    endtask

    function automatic bit pow_nz();
        for (int i = 0; i < BN; i++) if (bn_pow[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic atan_inv(input int unsigned x);
        int k;
        for (int i = 0; i < BN; i++) begin bn_acc[i] = 0; bn_pow[i] = 0; end
        bn_pow[0] = 1;
        div_pow(64'(x));
        k = 0;
        while (pow_nz()) begin
            div_into_t(64'(2 * k + 1));
            acc_addsub(k[0]);
            div_pow(64'(x) * 64'(x));
            k++;
        end
    endtask

    task automatic build_tables();
        bit [63:0] s, c;
        bit [63:0] blk;
        atan_inv(5);
        c = 0;
        for (int i = BN - 1; i >= 0; i--) begin
            s = 64'(bn_acc[i]) * 16 + c; bn_pi[i] = s[31:0]; c = s >> 32;
        end
        atan_inv(239);
        c = 0;
        for (int i = BN - 1; i >= 0; i--) begin
            s = 64'(bn_acc[i]) * 4 + c; bn_t[i] = s[31:0]; c = s >> 32;
        end
        c = 0;
        for (int i = BN - 1; i >= 0; i--) begin
            s = 64'(bn_pi[i]) - 64'(bn_t[i]) - c; bn_pi[i] = s[31:0]; c = {63'b0, s[63]};
        end
        for (int j = 0; j < 18; j++) mp[j] = bn_pi[1 + j];
        for (int b = 0; b < 4; b++)
            for (int j = 0; j < 256; j++) sbox[b][j] = bn_pi[19 + b * 256 + j];
        // All-zero key: the key XOR leaves P untouched, only the self-encryption runs.
        blk = 0;
        for (int i = 0; i < 18; i += 2) begin
            blk = bf_crypt(blk, 1'b0); mp[i] = blk[63:32]; mp[i + 1] = blk[31:0];
        end
        for (int b = 0; b < 4; b++)
            for (int j = 0; j < 256; j += 2) begin
                blk = bf_crypt(blk, 1'b0); sbox[b][j] = blk[63:32]; sbox[b][j + 1] = blk[31:0];
            end
        for (int j = 0; j < 18; j++) bfp[j] = mp[j];
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic p_write(input logic [4:0] a, input logic [31:0] d, output bit err);
        bus.p_wr_en = 1'b1; bus.p_wr_addr = a; bus.p_wr_data = d;
        tick();
        bus.p_wr_en = 1'b0;
        err = bus.p_wr_err;
    endtask

    task automatic use_key(input bit bf);
        bit err, any_err;
        f_model_en = bf;
        if (cur_key != int'(bf)) begin
            any_err = 1'b0;
            for (int i = 0; i < 18; i++) begin
                p_write(5'(i), bf ? bfp[i] : 32'h0, err);
                any_err |= err;
            end
            check("p_load_err", {63'b0, any_err}, 64'd0);
            cur_key = int'(bf);
        end
    endtask

    task automatic wait_out(input int start, output int lat);
        lat = start;
        while (!bus.out_valid && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic take_out();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    // Mode and data are scrambled after acceptance; the block must ignore them.
    task automatic run_block(input bit dec, input logic [63:0] din, output logic [63:0] dout, output int lat);
        bus.mode = dec; bus.in_data = din; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.mode = ~dec; bus.in_data = 64'hA5A5_5A5A_C3C3_3C3C;
        wait_out(1, lat);
        dout = bus.out_data;
        take_out();
    endtask

    typedef struct {
        string       name;
        bit          bf;
        bit          dec;
        logic [63:0] din;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [63:0] dout, exp_m;
        int          lat;
        bit          err, seen;

        reset = 1'b1;
        bus.mode = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        bus.p_wr_en = 1'b0; bus.p_wr_addr = '0; bus.p_wr_data = '0;

        vecs[0] = '{"enc_zero_p", 1'b0, 1'b0, 64'h0123456789ABCDEF, 64'h89ABCDEF01234567};
        vecs[1] = '{"dec_zero_p", 1'b0, 1'b1, 64'hFFFFFFFF00000000, 64'h00000000FFFFFFFF};
        vecs[2] = '{"enc_zero_all", 1'b0, 1'b0, 64'h0, 64'h0};
        vecs[3] = '{"dec_swap", 1'b0, 1'b1, 64'h0123456789ABCDEF, 64'h89ABCDEF01234567};
        vecs[4] = '{"bf_enc_zero", 1'b1, 1'b0, 64'h0, 64'h4EF997456198DD78};
        vecs[5] = '{"bf_dec_back", 1'b1, 1'b1, 64'h4EF997456198DD78, 64'h0};

        build_tables();

        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check("rst_in_ready", {63'b0, bus.in_ready}, 64'd1);
        check("rst_busy", {63'b0, bus.busy}, 64'd0);
        check("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
        check("rst_out_data", bus.out_data, 64'd0);
        check("rst_p_wr_err", {63'b0, bus.p_wr_err}, 64'd0);
        check("rst_f_in", {32'b0, bus.f_in}, 64'd0);

        foreach (vecs[i]) begin
            use_key(vecs[i].bf);
            run_block(vecs[i].dec, vecs[i].din, dout, lat);
            check({vecs[i].name, "_out"}, dout, vecs[i].exp);
            check({vecs[i].name, "_lat"}, 64'(lat), 64'd18);
        end

        // Result held in HOLD while a second block is already offered.
        use_key(1'b0);
        bus.mode = 1'b0; bus.in_data = 64'h0123456789ABCDEF; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_out(1, lat);
        check("hold_lat", 64'(lat), 64'd18);
        bus.in_valid = 1'b1; bus.in_data = 64'hFFFFFFFF00000000; bus.mode = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("hold_data", bus.out_data, 64'h89ABCDEF01234567);
            check("hold_in_ready", {63'b0, bus.in_ready}, 64'd0);
            tick();
        end
        check("hold_valid", {63'b0, bus.out_valid}, 64'd1);
        check("hold_f_in", {32'b0, bus.f_in}, 64'd0);
        take_out();
        check("release_valid", {63'b0, bus.out_valid}, 64'd0);
        check("release_busy", {63'b0, bus.busy}, 64'd0);
        tick();
        check("second_accept_busy", {63'b0, bus.busy}, 64'd1);
        bus.in_valid = 1'b0;
        wait_out(1, lat);
        check("second_out", bus.out_data, 64'h00000000FFFFFFFF);
        check("second_lat", 64'(lat), 64'd18);
        take_out();

        // Rejected writes: one during ROUND, one out of range in IDLE.
        bus.mode = 1'b0; bus.in_data = 64'h0123456789ABCDEF; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        p_write(5'd0, 32'hDEADBEEF, err);
        check("err_round", {63'b0, err}, 64'd1);
        tick();
        check("err_round_clr", {63'b0, bus.p_wr_err}, 64'd0);
        wait_out(3, lat);
        check("err_round_lat", 64'(lat), 64'd18);
        check("err_round_out", bus.out_data, 64'h89ABCDEF01234567);
        take_out();
        p_write(5'd18, 32'hCAFEF00D, err);
        check("err_addr", {63'b0, err}, 64'd1);
        tick();
        check("err_addr_clr", {63'b0, bus.p_wr_err}, 64'd0);
        run_block(1'b0, 64'h0123456789ABCDEF, dout, lat);
        check("err_rerun_out", dout, 64'h89ABCDEF01234567);

        // Abort at round 7; P must survive the reset.
        use_key(1'b1);
        bus.mode = 1'b0; bus.in_data = 64'h0; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        #1;
        check("abort_busy", {63'b0, bus.busy}, 64'd0);
        check("abort_out_data", bus.out_data, 64'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check("abort_in_ready", {63'b0, bus.in_ready}, 64'd1);
        seen = 1'b0;
        repeat (25) begin
            tick();
            seen |= bus.out_valid;
        end
        check("abort_no_valid", {63'b0, seen}, 64'd0);
        run_block(1'b0, 64'h0, dout, lat);
        check("abort_next_out", dout, 64'h4EF997456198DD78);
        check("abort_next_lat", 64'(lat), 64'd18);

        // P write in the acceptance cycle must be seen by that block.
        mp[0] = 32'h12345678;
        exp_m = bf_crypt(64'h0011223344556677, 1'b0);
        bus.p_wr_en = 1'b1; bus.p_wr_addr = 5'd0; bus.p_wr_data = 32'h12345678;
        bus.mode = 1'b0; bus.in_data = 64'h0011223344556677; bus.in_valid = 1'b1;
        tick();
        bus.p_wr_en = 1'b0; bus.in_valid = 1'b0;
        check("same_cycle_err", {63'b0, bus.p_wr_err}, 64'd0);
        wait_out(1, lat);
        dout = bus.out_data;
        check("same_cycle_out", dout, exp_m);
        take_out();
        run_block(1'b1, dout, dout, lat);
        check("same_cycle_dec", dout, 64'h0011223344556677);
        p_write(5'd0, bfp[0], err);
        mp[0] = bfp[0];

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/blowfish_round_ctrl.md
BLOWFISH_ROUND_CTRL -- requirements
Module: blowfish_round_ctrl

Interface
REQ-001 The block SHALL have parameter ROUNDS, default 16, giving the Feistel round count (even, 2..16); the P-array depth SHALL be ROUNDS+2.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port mode, input, 1, sampled on block acceptance: 0 = encrypt, 1 = decrypt.
REQ-005 The block SHALL have port in_valid, input, 1, input block offered.
REQ-006 The block SHALL have port in_data, input, 64, input block; bits [63:32] = L, bits [31:0] = R.
REQ-007 The block SHALL have port in_ready, output, 1, block can be accepted this cycle.
REQ-008 The block SHALL have port out_valid, output, 1, result held on out_data.
REQ-009 The block SHALL have port out_data, output, 64, result block {L,R}.
REQ-010 The block SHALL have port out_ready, input, 1, consumer takes the result.
REQ-011 The block SHALL have port p_wr_en, input, 1, P-array write strobe.
REQ-012 The block SHALL have port p_wr_addr, input, 5, P-array entry index.
REQ-013 The block SHALL have port p_wr_data, input, 32, P-array write data.
REQ-014 The block SHALL have port p_wr_err, output, 1, one-cycle pulse flagging a rejected write.
REQ-015 The block SHALL have port f_in, output, 32, operand to the external combinational F-function unit.
REQ-016 The block SHALL have port f_out, input, 32, F(f_in), valid in the same cycle.
REQ-017 The block SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ROUND, FINAL and HOLD.
REQ-019 in_ready SHALL equal 1 only in IDLE.
REQ-020 Acceptance SHALL occur on in_valid && in_ready; it loads L/R from in_data, latches mode, clears round counter k, and moves the FSM to ROUND.
REQ-021 P index per round SHALL be idx = k in encrypt and idx = ROUNDS+1-k in decrypt.
REQ-022 In ROUND, f_in SHALL equal L ^ P[idx].
REQ-023 Each ROUND edge SHALL load L <= R ^ f_out and R <= L ^ P[idx] (swap included), then increment k.
REQ-024 On the edge where k = ROUNDS-1, the FSM SHALL move to FINAL; k is 5 bits and never wraps.
REQ-025 On the FINAL edge, out_data SHALL be loaded with {R ^ Pa, L ^ Pb}.
REQ-026 Pa/Pb SHALL be P[ROUNDS+1]/P[ROUNDS] in encrypt and P[0]/P[1] in decrypt.
REQ-027 On the FINAL edge, out_valid SHALL be set and the FSM SHALL move to HOLD.
REQ-028 Latency SHALL be exactly ROUNDS+2 cycles from the acceptance edge to out_valid high (18 at default).
REQ-029 In HOLD, out_data and out_valid SHALL remain stable until out_ready = 1; on that edge out_valid clears and the FSM returns to IDLE.
REQ-030 A new block SHALL be accepted no earlier than the cycle after the HOLD-to-IDLE edge; there is no bypass.
REQ-031 f_in SHALL be driven to 0 outside ROUND.
REQ-032 P writes SHALL be honoured only in IDLE and only for p_wr_addr <= ROUNDS+1.
REQ-033 A write in any other state or to an out-of-range address SHALL be dropped and SHALL raise p_wr_err for one cycle.
REQ-034 A write coinciding with an acceptance in the same IDLE cycle SHALL take effect, so the new P value is used by that block.
REQ-035 in_valid deassertion after acceptance SHALL NOT affect the operation; mode changes mid-operation SHALL be ignored.

Reset
REQ-036 On reset: FSM = IDLE, k = 0, L = R = 0, out_data = 0, out_valid = 0, p_wr_err = 0, busy = 0, in_ready = 1 after release.
REQ-037 The P-array SHALL NOT be cleared by reset; it retains its contents, undefined until first written.
REQ-038 Reset asserted mid-ROUND or in HOLD SHALL abort the block with no out_valid pulse.

Verification
REQ-039 The bench SHALL cover: P all 0, f_out tied 0, encrypt in_data = 0x0123456789ABCDEF -> out_data = 0x89ABCDEF01234567 with out_valid exactly 18 cycles after acceptance.
REQ-040 The bench SHALL cover: F = standard Blowfish S-box model, P/S from all-zero key, encrypt 0x0000000000000000 -> 0x4EF997456198DD78; decrypt of that result -> 0x0000000000000000.
REQ-041 The bench SHALL cover: out_ready held 0 for 5 cycles in HOLD -> out_data stable, in_ready = 0, a second in_valid not accepted until the cycle after out_ready = 1.
REQ-042 The bench SHALL cover: p_wr_en during ROUND, and p_wr_addr = 18 in IDLE -> p_wr_err pulses 1 cycle each and P is unchanged (re-run REQ-039 vector gives the same result).
REQ-043 The bench SHALL cover: reset at round 7 -> out_valid stays 0, in_ready = 1 after release, and the next block completes correctly.
REQ-044 The bench SHALL cover: P write and acceptance in the same cycle -> the block uses the new P value, checked against the reference model.
